useq_prog_loader: RTL

//  Owns the microsequencer's 256x8 program store and fills it from a byte stream (host/UART side).

---
 rtl/useq_pkg.sv | 31 +++
 rtl/useq_store.sv | 28 ++
 rtl/useq_prog_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/useq_pkg.sv
// Shared microsequencer definitions: loader state encoding, store geometry,
// core opcodes and the running-checksum helper.
package useq_pkg;

  localparam int USEQ_ADDR_W = 8;
  localparam int USEQ_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_PAY  = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } ld_state_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h10;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h30;
  localparam logic [7:0] OP_STA = 8'h40;
  localparam logic [7:0] OP_JMP = 8'h50;
  localparam logic [7:0] OP_JZ  = 8'h60;
  localparam logic [7:0] OP_HLT = 8'hFF;

  // Image checksum is the byte-wise sum modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/useq_store.sv
// Program store: one synchronous write port, one asynchronous read port
// (distributed RAM). Contents are deliberately not reset.
module useq_store
  import useq_pkg::*;
#(
  parameter int ADDR_W = USEQ_ADDR_W,
  parameter int DATA_W = USEQ_DATA_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  // Write port; a same-cycle read sees the old word until this edge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/useq_prog_loader.sv
// Program loader: receives a length-framed, checksummed byte image into the
// program store and holds the core in reset until the image verifies.
module useq_prog_loader
  import useq_pkg::*;
#(
  parameter int ADDR_W  = USEQ_ADDR_W,
  parameter int DATA_W  = USEQ_DATA_W,
  parameter int AUTORUN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic              i_ld_start,
  input  logic [7:0]        i_ld_data,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  output logic              o_core_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam ld_state_t RST_STATE = (AUTORUN != 0) ? ST_RUN : ST_IDLE;
  localparam logic      RST_RUN   = (AUTORUN != 0);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  ld_state_t         r_state;
  ld_state_t         w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_sum;
  logic              r_ld_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_core_rst_n;
  logic              r_err;
  logic              w_accept;
  logic              w_we;

  // ld_start takes priority, so a byte offered alongside it is not consumed.
  assign w_accept = i_ld_valid && r_ld_ready && !i_ld_start;

  // Next-state decode and store write enable.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    if (i_ld_start) begin
      w_state_nxt = ST_LEN;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_LEN:  w_state_nxt = w_accept ? ST_PAY : ST_LEN;
        ST_PAY: begin
          w_we = w_accept;
          if (w_accept && (r_cnt == CNT_ONE)) begin
            w_state_nxt = ST_CSUM;
          end else begin
            w_state_nxt = ST_PAY;
          end
        end
        ST_CSUM: begin
          if (!w_accept) begin
            w_state_nxt = ST_CSUM;
          end else if (i_ld_data == r_sum) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
        ST_RUN:  w_state_nxt = ST_RUN;
        ST_ERR:  w_state_nxt = ST_ERR;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, counters, checksum and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RST_STATE;
      r_cnt        <= {(ADDR_W+1){1'b0}};
      r_waddr      <= {ADDR_W{1'b0}};
      r_sum        <= 8'h00;
      r_ld_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= RST_RUN;
      r_core_rst_n <= RST_RUN;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= (w_state_nxt == ST_LEN) || (w_state_nxt == ST_PAY) ||
                      (w_state_nxt == ST_CSUM);
      r_ld_ready   <= (w_state_nxt == ST_LEN) || (w_state_nxt == ST_PAY) ||
                      (w_state_nxt == ST_CSUM);
      r_done       <= (w_state_nxt == ST_RUN);
      r_core_rst_n <= (w_state_nxt == ST_RUN);
      r_err        <= (w_state_nxt == ST_ERR);
      if (w_accept) begin
        case (r_state)
          ST_LEN: begin
            // A zero length byte encodes a full 2**ADDR_W image.
            r_cnt   <= (i_ld_data == 8'h00) ? CNT_MAX : (ADDR_W+1)'(i_ld_data);
            r_waddr <= {ADDR_W{1'b0}};
            r_sum   <= 8'h00;
          end
          ST_PAY: begin
            r_cnt   <= r_cnt - CNT_ONE;
            r_waddr <= r_waddr + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_sum   <= csum_add(r_sum, i_ld_data);
          end
          default: begin
            r_cnt <= r_cnt;
          end
        endcase
      end
    end
  end

  useq_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_waddr),
    .i_wdata (DATA_W'(i_ld_data)),
    .i_raddr (i_mem_addr),
    .o_rdata (o_mem_data)
  );

  assign o_ld_ready   = r_ld_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_core_rst_n = r_core_rst_n;
  assign o_err        = r_err;

endmodule
